// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl
//   SPI slave transaction controller (mode 0, MSB first) that runs entirely on
//   the system clock. The raw SPI pins are synchronised and edge-detected. Each
//   frame is a command byte followed by one data byte. The controller either
//   writes the data byte into a small register bank or shifts a register back
//   out on sdo.
//
// Ports
//   clk        system clock, the only clock of the block
//   rst        asynchronous active-high reset
//   sck        raw SPI clock (asynchronous to clk, at most f_clk/8)
//   sdi        raw SPI data, master to slave
//   nss        raw SPI slave select, active low
//   sdo        SPI data, slave to master; 0 when no read data is being driven
//   regs_out   register bank, reg[i] at [8*i+7:8*i]
//   wr_pulse   one-cycle strobe in the cycle a register is written
//   wr_addr    register address of the write, valid with wr_pulse
//   frame_err  one-cycle strobe when a frame is aborted before completion
//   busy       high while a frame is in progress
module spi_reg_ctrl #(
   parameter int NREG        = 4,
   parameter int SYNC_STAGES = 2,
   localparam int AW         = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sck,
   input  logic                sdi,
   input  logic                nss,
   output logic                sdo,
   output logic [8*NREG-1:0]   regs_out,
   output logic                wr_pulse,
   output logic [AW-1:0]       wr_addr,
   output logic                frame_err,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

   // Input synchronisers; the last stage is the synchronised value.
   logic [SYNC_STAGES-1:0] sck_sync_reg;
   logic [SYNC_STAGES-1:0] sdi_sync_reg;
   logic [SYNC_STAGES-1:0] nss_sync_reg;
   logic                   sck_d_reg;
   logic                   nss_d_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync_reg <= '0;
         sdi_sync_reg <= '0;
         nss_sync_reg <= '0;
         sck_d_reg    <= 1'b0;
         nss_d_reg    <= 1'b0;
      end else begin
         sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
         sdi_sync_reg <= {sdi_sync_reg[SYNC_STAGES-2:0], sdi};
         nss_sync_reg <= {nss_sync_reg[SYNC_STAGES-2:0], nss};
         sck_d_reg    <= sck_sync_reg[SYNC_STAGES-1];
         nss_d_reg    <= nss_sync_reg[SYNC_STAGES-1];
      end
   end

   logic sck_s, sdi_s, nss_s;
   logic sck_rise, sck_fall, nss_rise, nss_fall;

   assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
   assign sdi_s    = sdi_sync_reg[SYNC_STAGES-1];
   assign nss_s    = nss_sync_reg[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d_reg;
   assign sck_fall = ~sck_s & sck_d_reg;
   assign nss_rise = nss_s & ~nss_d_reg;
   assign nss_fall = ~nss_s & nss_d_reg;

   // Transaction state
   state_t          state_reg;
   logic [3:0]      bitcnt_reg;
   logic [6:0]      shift_in_reg;
   logic [7:0]      shift_out_reg;
   logic            cmd_w_reg;
   logic [AW-1:0]   addr_reg;
   logic            sdo_reg;
   logic            wr_pulse_reg;
   logic [AW-1:0]   wr_addr_reg;
   logic            frame_err_reg;
   logic [7:0]      regs_reg [NREG];

   // Byte as it stands including the bit sampled on the current rise.
   logic [7:0] rx_byte;
   assign rx_byte = {shift_in_reg, sdi_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         bitcnt_reg    <= '0;
         shift_in_reg  <= '0;
         shift_out_reg <= '0;
         cmd_w_reg     <= 1'b0;
         addr_reg      <= '0;
         sdo_reg       <= 1'b0;
         wr_pulse_reg  <= 1'b0;
         wr_addr_reg   <= '0;
         frame_err_reg <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            regs_reg[i] <= '0;
         end
      end else begin
         wr_pulse_reg  <= 1'b0;
         frame_err_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               sdo_reg <= 1'b0;
               if (nss_fall) begin
                  bitcnt_reg <= '0;
                  state_reg  <= CMD;
               end
            end

            CMD: begin
               if (nss_rise) begin
                  state_reg     <= IDLE;
                  bitcnt_reg    <= '0;
                  sdo_reg       <= 1'b0;
                  frame_err_reg <= 1'b1;
               end else if (sck_rise) begin
                  shift_in_reg <= rx_byte[6:0];
                  bitcnt_reg   <= bitcnt_reg + 4'd1;
                  if (bitcnt_reg == 4'd7) begin
                     // Command complete; preload the read data so the first
                     // bit can be presented on the following sck fall.
                     cmd_w_reg     <= rx_byte[7];
                     addr_reg      <= rx_byte[AW-1:0];
                     shift_out_reg <= regs_reg[rx_byte[AW-1:0]];
                     state_reg     <= DATA;
                  end
               end
            end

            DATA: begin
               // The 16th rise takes priority over a simultaneous nss rise so
               // that a frame whose last edge coincides with deselect still
               // completes its write.
               if (sck_rise && bitcnt_reg == 4'd15) begin
                  bitcnt_reg <= '0;
                  sdo_reg    <= 1'b0;
                  if (cmd_w_reg) begin
                     regs_reg[addr_reg] <= rx_byte;
                     wr_pulse_reg       <= 1'b1;
                     wr_addr_reg        <= addr_reg;
                  end
                  state_reg <= nss_rise ? IDLE : DONE;
               end else if (nss_rise) begin
                  state_reg     <= IDLE;
                  bitcnt_reg    <= '0;
                  sdo_reg       <= 1'b0;
                  frame_err_reg <= 1'b1;
               end else if (sck_rise) begin
                  shift_in_reg <= rx_byte[6:0];
                  bitcnt_reg   <= bitcnt_reg + 4'd1;
               end else if (sck_fall && !cmd_w_reg) begin
                  sdo_reg       <= shift_out_reg[7];
                  shift_out_reg <= {shift_out_reg[6:0], 1'b0};
               end
            end

            DONE: begin
               // Extra bytes are silently discarded until deselect.
               sdo_reg <= 1'b0;
               if (nss_rise) begin
                  state_reg  <= IDLE;
                  bitcnt_reg <= '0;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_regs_out
         assign regs_out[8*gi +: 8] = regs_reg[gi];
      end
   endgenerate

   assign sdo       = sdo_reg;
   assign wr_pulse  = wr_pulse_reg;
   assign wr_addr   = wr_addr_reg;
   assign frame_err = frame_err_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl
//   Directed bench for spi_reg_ctrl. Expected register writes are queued when
//   a frame is driven and popped by a monitor when wr_pulse fires. Read data,
//   strobe counts, busy and the bank contents are checked after each frame.
module tb_spi_reg_ctrl;

   localparam int NREG = 4;
   localparam int SS   = 2;
   localparam int HALF = 60;   // sck half period in ns (clk period 10 ns)

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sck = 1'b0;
   logic        sdi = 1'b0;
   logic        nss = 1'b1;
   logic        sdo;
   logic [31:0] regs_out;
   logic        wr_pulse;
   logic [1:0]  wr_addr;
   logic        frame_err;
   logic        busy;

   always #5 clk = ~clk;

   spi_reg_ctrl #(.NREG(NREG), .SYNC_STAGES(SS)) dut (
      .clk       (clk),
      .rst       (rst),
      .sck       (sck),
      .sdi       (sdi),
      .nss       (nss),
      .sdo       (sdo),
      .regs_out  (regs_out),
      .wr_pulse  (wr_pulse),
      .wr_addr   (wr_addr),
      .frame_err (frame_err),
      .busy      (busy)
   );

   typedef struct packed {
      logic [1:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_assert = 0;
   int  n_fail   = 0;
   int  wr_cnt   = 0;
   int  err_cnt  = 0;
   logic [7:0] rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Monitor: counts strobes and checks each write against the scoreboard.
   always begin
      @(negedge clk);
      if (wr_pulse || frame_err)
         check("pulse_exclusive", 32'(wr_pulse & frame_err), 32'd0);
      if (frame_err) err_cnt++;
      if (wr_pulse) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
            @(negedge clk);
            check("wr_data", 32'(regs_out[8*mon_e.addr +: 8]), 32'(mon_e.data));
         end
      end
   end

   // mode 0: normal frame, nss released after the last bit
   // mode 1: nss released together with the last sck rise
   // mode 2: nss left low after nbits (caller aborts the frame)
   task automatic xfer(input logic [23:0] data, input int nbits, input int mode,
                       output logic [7:0] rdata);
      rdata = 8'h00;
      nss = 1'b0;
      #(2*HALF);
      for (int i = 0; i < nbits; i++) begin
         sdi = data[23-i];
         #HALF;
         if (i >= 8 && i < 16) rdata = {rdata[6:0], sdo};
         sck = 1'b1;
         if (mode == 1 && i == nbits-1) nss = 1'b1;
         #HALF;
         sck = 1'b0;
      end
      sdi = 1'b0;
      if (mode != 2) begin
         #HALF;
         nss = 1'b1;
         #(4*HALF);
      end
      $display("xfer data=%h bits=%0d mode=%0d rd=%h", data, nbits, mode, rdata);
   endtask

   initial begin
      // Reset state
      #23;
      check("rst_regs", regs_out, 32'h0);
      check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sdo", 32'(sdo), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #200;

      // 1. Write reg1
      exp_q.push_back('{addr: 2'd1, data: 8'h5A});
      xfer(24'h815A00, 16, 0, rd);
      check("t1_regs", regs_out, 32'h00005A00);
      check("t1_wr_cnt", 32'(wr_cnt), 32'd1);
      check("t1_err_cnt", 32'(err_cnt), 32'd0);
      check("t1_queue", 32'(exp_q.size()), 32'd0);

      // 2. Read reg1
      xfer(24'h010000, 16, 0, rd);
      check("t2_rdata", 32'(rd), 32'h5A);
      check("t2_regs", regs_out, 32'h00005A00);
      check("t2_wr_cnt", 32'(wr_cnt), 32'd1);
      check("t2_sdo_idle", 32'(sdo), 32'd0);
      check("t2_busy", 32'(busy), 32'd0);

      // 3. Abort after 12 bits
      xfer(24'h82FF00, 12, 2, rd);
      check("t3_busy_mid", 32'(busy), 32'd1);
      nss = 1'b1;
      #(4*HALF);
      check("t3_err_cnt", 32'(err_cnt), 32'd1);
      check("t3_busy_after", 32'(busy), 32'd0);
      check("t3_regs", regs_out, 32'h00005A00);
      check("t3_wr_cnt", 32'(wr_cnt), 32'd1);

      // 4. Overrun: third byte discarded
      exp_q.push_back('{addr: 2'd3, data: 8'h3C});
      xfer(24'h833CFF, 24, 0, rd);
      check("t4_regs", regs_out, 32'h3C005A00);
      check("t4_wr_cnt", 32'(wr_cnt), 32'd2);
      check("t4_err_cnt", 32'(err_cnt), 32'd1);

      // 5. Reset mid-frame, checked before any further clock edge
      xfer(24'h801100, 10, 2, rd);
      #2;
      rst = 1'b1;
      #1;
      check("t5_rst_regs", regs_out, 32'h0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_sdo", 32'(sdo), 32'd0);
      check("t5_rst_wr", 32'(wr_pulse), 32'd0);
      check("t5_rst_err", 32'(frame_err), 32'd0);
      #50;
      nss = 1'b1;
      #30;
      @(negedge clk);
      rst = 1'b0;
      #200;
      check("t5_err_cnt", 32'(err_cnt), 32'd1);
      check("t5_wr_cnt", 32'(wr_cnt), 32'd2);
      exp_q.push_back('{addr: 2'd0, data: 8'h22});
      xfer(24'h802200, 16, 0, rd);
      check("t5_regs", regs_out, 32'h00000022);
      check("t5_wr_cnt2", 32'(wr_cnt), 32'd3);

      // 6. sck noise while deselected, then a clean write
      for (int i = 0; i < 20; i++) begin
         sck = ~sck;
         sdi = 1'($urandom);
         #HALF;
      end
      sck = 1'b0;
      sdi = 1'b0;
      #200;
      check("t6_noise_wr", 32'(wr_cnt), 32'd3);
      check("t6_noise_err", 32'(err_cnt), 32'd1);
      check("t6_noise_busy", 32'(busy), 32'd0);
      exp_q.push_back('{addr: 2'd1, data: 8'hA5});
      xfer(24'h81A500, 16, 0, rd);
      check("t6_regs", regs_out, 32'h0000A522);
      check("t6_wr_cnt", 32'(wr_cnt), 32'd4);

      // 7. nss rise coincident with the 16th sck rise: write completes, no error
      exp_q.push_back('{addr: 2'd2, data: 8'h77});
      xfer(24'h827700, 16, 1, rd);
      check("t7_regs", regs_out, 32'h0077A522);
      check("t7_wr_cnt", 32'(wr_cnt), 32'd5);
      check("t7_err_cnt", 32'(err_cnt), 32'd1);
      check("t7_busy", 32'(busy), 32'd0);
      check("final_queue", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
